// File: rtl/rtclock_trigger_sched.sv
// rtclock_trigger_sched: in-order FIFO of absolute (sec, nsec, id) targets, fired against the running rtclock.
// Build macro RTCLOCK_SCHED_LATE_DROP_EN: late entries pulse trig_late alone instead of firing.
module rtclock_trigger_sched #(
    parameter int DEPTH      = 4,
    parameter int SEC_WIDTH  = 48,
    parameter int NSEC_WIDTH = 30,
    parameter int ID_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [SEC_WIDTH-1:0]      sec,
    input  logic [NSEC_WIDTH-1:0]     nsec,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [SEC_WIDTH-1:0]      req_sec,
    input  logic [NSEC_WIDTH-1:0]     req_nsec,
    input  logic [ID_WIDTH-1:0]       req_id,
    input  logic                      flush,
    output logic                      trig_valid,
    output logic [ID_WIDTH-1:0]       trig_id,
    output logic                      trig_late,
    output logic                      req_err,
    output logic                      armed,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0]         PTR_ONE    = AW'(1'b1);
    localparam logic [LW-1:0]         LVL_ONE    = LW'(1'b1);
    localparam logic [LW-1:0]         LVL_FULL   = LW'(DEPTH);
    localparam logic [NSEC_WIDTH-1:0] NSEC_LIMIT = NSEC_WIDTH'(32'd1_000_000_000);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2,
        ST_FIRE  = 2'd3
    } state_t;

    logic [SEC_WIDTH-1:0]  fifo_sec_r  [DEPTH];
    logic [NSEC_WIDTH-1:0] fifo_nsec_r [DEPTH];
    logic [ID_WIDTH-1:0]   fifo_id_r   [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [LW-1:0]         level_r;

    state_t                state_r;
    logic [SEC_WIDTH-1:0]  t_sec_r;
    logic [NSEC_WIDTH-1:0] t_nsec_r;
    logic [ID_WIDTH-1:0]   t_id_r;
    logic                  first_r;
    logic                  trig_valid_r;
    logic [ID_WIDTH-1:0]   trig_id_r;
    logic                  trig_late_r;
    logic                  req_err_r;
    logic                  armed_r;

    logic                  full_s;
    logic                  accept_s;
    logic                  nsec_ok_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  busy_s;
    logic                  hit_s;
    logic                  late_s;
    logic                  fire_valid_s;

    // Ready is driven from the registered level so a same-cycle pop never raises it.
    assign full_s    = (level_r == LVL_FULL);
    assign req_ready = !full_s && !flush;
    assign accept_s  = req_valid && req_ready;
    assign nsec_ok_s = (req_nsec < NSEC_LIMIT);
    assign push_s    = accept_s && nsec_ok_s;
    assign pop_s     = (state_r == ST_LOAD);
    assign busy_s    = (level_r != '0) || push_s;

    assign hit_s  = (sec > t_sec_r) || ((sec == t_sec_r) && (nsec >= t_nsec_r));
    assign late_s = first_r && ((sec > t_sec_r) || (nsec > t_nsec_r));

`ifdef RTCLOCK_SCHED_LATE_DROP_EN
    assign fire_valid_s = !late_s;
`else
    assign fire_valid_s = 1'b1;
`endif

    // FIFO storage: written only for accepted requests with a legal nsec.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_sec_r[i]  <= '0;
                fifo_nsec_r[i] <= '0;
                fifo_id_r[i]   <= '0;
            end
        end else if (push_s) begin
            fifo_sec_r[wr_ptr_r]  <= req_sec;
            fifo_nsec_r[wr_ptr_r] <= req_nsec;
            fifo_id_r[wr_ptr_r]   <= req_id;
        end else begin
            fifo_sec_r[wr_ptr_r]  <= fifo_sec_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy; flush empties everything.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Error pulse for a consumed request whose nsec is out of range.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_err_r <= 1'b0;
        end else begin
            req_err_r <= accept_s && !nsec_ok_s;
        end
    end

    // Scheduler FSM: load head, compare against the clock, pulse the trigger outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            t_sec_r      <= '0;
            t_nsec_r     <= '0;
            t_id_r       <= '0;
            first_r      <= 1'b0;
            trig_valid_r <= 1'b0;
            trig_id_r    <= '0;
            trig_late_r  <= 1'b0;
            armed_r      <= 1'b0;
        end else if (flush) begin
            state_r      <= ST_IDLE;
            first_r      <= 1'b0;
            trig_valid_r <= 1'b0;
            trig_late_r  <= 1'b0;
            armed_r      <= 1'b0;
        end else begin
            trig_valid_r <= 1'b0;
            trig_late_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (busy_s) begin
                        state_r <= ST_LOAD;
                        armed_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        armed_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    t_sec_r  <= fifo_sec_r[rd_ptr_r];
                    t_nsec_r <= fifo_nsec_r[rd_ptr_r];
                    t_id_r   <= fifo_id_r[rd_ptr_r];
                    first_r  <= 1'b1;
                    state_r  <= ST_ARMED;
                    armed_r  <= 1'b1;
                end
                ST_ARMED: begin
                    first_r <= 1'b0;
                    armed_r <= 1'b1;
                    if (hit_s) begin
                        state_r      <= ST_FIRE;
                        trig_valid_r <= fire_valid_s;
                        trig_id_r    <= t_id_r;
                        trig_late_r  <= late_s;
                    end else begin
                        state_r <= ST_ARMED;
                    end
                end
                ST_FIRE: begin
                    if (busy_s) begin
                        state_r <= ST_LOAD;
                        armed_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        armed_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    armed_r <= 1'b0;
                end
            endcase
        end
    end

    assign trig_valid = trig_valid_r;
    assign trig_id    = trig_id_r;
    assign trig_late  = trig_late_r;
    assign req_err    = req_err_r;
    assign armed      = armed_r;
    assign level      = level_r;

endmodule

// File: tb/tb_rtclock_trigger_sched.sv
// Directed self-checking bench for rtclock_trigger_sched; the bench drives sec/nsec directly.
module tb_rtclock_trigger_sched;

    localparam int SW = 48;
    localparam int NW = 30;
    localparam int IW = 4;

`ifdef RTCLOCK_SCHED_LATE_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic [SW-1:0] sec;
    logic [NW-1:0] nsec;
    logic          req_valid;
    logic          req_ready;
    logic [SW-1:0] req_sec;
    logic [NW-1:0] req_nsec;
    logic [IW-1:0] req_id;
    logic          flush;
    logic          trig_valid;
    logic [IW-1:0] trig_id;
    logic          trig_late;
    logic          req_err;
    logic          armed;
    logic [2:0]    level;

    int n_checks = 0;
    int n_fail   = 0;

    rtclock_trigger_sched #(
        .DEPTH(4), .SEC_WIDTH(SW), .NSEC_WIDTH(NW), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .resetn(resetn), .sec(sec), .nsec(nsec),
        .req_valid(req_valid), .req_ready(req_ready), .req_sec(req_sec),
        .req_nsec(req_nsec), .req_id(req_id), .flush(flush),
        .trig_valid(trig_valid), .trig_id(trig_id), .trig_late(trig_late),
        .req_err(req_err), .armed(armed), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [SW-1:0] s, input logic [NW-1:0] ns, input logic [IW-1:0] id);
        req_sec   = s;
        req_nsec  = ns;
        req_id    = id;
        req_valid = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, req_ready,  1);
        check_eq({tag, "_tv"},    trig_valid, 0);
        check_eq({tag, "_tid"},   trig_id,    0);
        check_eq({tag, "_late"},  trig_late,  0);
        check_eq({tag, "_err"},   req_err,    0);
        check_eq({tag, "_armed"}, armed,      0);
        check_eq({tag, "_level"}, level,      0);
    endtask

    // Push into an idle block with a target that is due at the first compare.
    task automatic run_due(input string tag, input logic [SW-1:0] s, input logic [NW-1:0] ns,
                           input logic [IW-1:0] id, input bit exp_late);
        bit exp_v;
        exp_v = !(exp_late && DROP);
        drive_req(s, ns, id);
        tick();
        req_valid = 1'b0;
        check_eq({tag, "_tv_c1"}, trig_valid, 0);
        tick();
        check_eq({tag, "_tv_c2"}, trig_valid, 0);
        tick();
        check_eq({tag, "_tv_c3"}, trig_valid, exp_v);
        check_eq({tag, "_late"},  trig_late,  exp_late);
        if (exp_v) check_eq({tag, "_id"}, trig_id, id);
        tick();
        check_eq({tag, "_tv_c4"},   trig_valid, 0);
        check_eq({tag, "_late_c4"}, trig_late,  0);
        check_eq({tag, "_armed_c4"}, armed,     0);
    endtask

    initial begin
        resetn    = 1'b0;
        sec       = 48'd5;
        nsec      = 30'd0;
        req_valid = 1'b0;
        req_sec   = '0;
        req_nsec  = '0;
        req_id    = '0;
        flush     = 1'b0;
        #12;
        check_reset_outputs("rst");
        tick();
        resetn = 1'b1;
        tick();

        // Future target: fires one cycle after the first nsec >= 800.
        drive_req(48'd5, 30'd800, 4'd3);
        for (int k = 1; k <= 9; k++) begin
            tick();
            req_valid = 1'b0;
            nsec = NW'(100 * k);
            check_eq($sformatf("fut_tv_k%0d", k), trig_valid, (k == 9));
            if (k == 1) begin
                check_eq("fut_level_k1", level, 1);
                check_eq("fut_armed_k1", armed, 1);
            end
            if (k == 9) begin
                check_eq("fut_id", trig_id, 3);
                check_eq("fut_late", trig_late, 0);
            end
        end
        tick();
        check_eq("fut_after_tv", trig_valid, 0);
        check_eq("fut_after_armed", armed, 0);

        // Exact equality at the first compare is on time; one ns past is late.
        sec  = 48'd6;
        nsec = 30'd500;
        run_due("eq", 48'd6, 30'd500, 4'd7, 1'b0);
        run_due("ns_past", 48'd6, 30'd499, 4'd8, 1'b1);

        // Past target by seconds.
        sec  = 48'd5;
        nsec = 30'd0;
        run_due("past", 48'd4, 30'd0, 4'd1, 1'b1);

        // Invalid nsec is consumed and flagged, never queued.
        drive_req(48'd5, 30'd1_000_000_000, 4'd9);
        tick();
        req_valid = 1'b0;
        check_eq("inv_err", req_err, 1);
        check_eq("inv_level", level, 0);
        check_eq("inv_armed", armed, 0);
        tick();
        check_eq("inv_err_clr", req_err, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("inv_tv_%0d", k), trig_valid, 0);
        end

        // Full FIFO: five far-future pushes, then release them all at once.
        for (int i = 0; i < 5; i++) begin
            drive_req(48'd100, 30'd0, IW'(i));
            check_eq($sformatf("full_ready_%0d", i), req_ready, 1);
            tick();
        end
        req_valid = 1'b0;
        check_eq("full_level", level, 4);
        check_eq("full_armed", armed, 1);
        check_eq("full_ready", req_ready, 0);
        sec = 48'd100;
        for (int c = 1; c <= 15; c++) begin
            bit exp_t;
            tick();
            exp_t = (c <= 13) && ((c - 1) % 3 == 0);
            check_eq($sformatf("full_tv_c%0d", c), trig_valid, exp_t);
            if (exp_t) check_eq($sformatf("full_id_c%0d", c), trig_id, (c - 1) / 3);
            if (c == 2) check_eq("full_ready_load", req_ready, 0);
            if (c == 3) check_eq("full_ready_after", req_ready, 1);
            if (c == 3) check_eq("full_level_after", level, 3);
            if (c == 15) check_eq("full_end_armed", armed, 0);
        end

        // Flush with 3 queued and 1 armed whose hit lands in the flush cycle.
        sec  = 48'd5;
        nsec = 30'd0;
        for (int i = 0; i < 4; i++) begin
            drive_req(48'd5, 30'd1000, IW'(10 + i));
            tick();
        end
        req_valid = 1'b0;
        check_eq("fl_level_pre", level, 3);
        check_eq("fl_armed_pre", armed, 1);
        nsec  = 30'd1000;
        flush = 1'b1;
        #1;
        check_eq("fl_ready_during", req_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        check_eq("fl_tv", trig_valid, 0);
        check_eq("fl_level", level, 0);
        check_eq("fl_armed", armed, 0);
        check_eq("fl_ready", req_ready, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq($sformatf("fl_tv_%0d", k), trig_valid, 0);
        end

        // Reset while armed with two entries queued.
        for (int i = 0; i < 3; i++) begin
            drive_req(48'd200, 30'd0, IW'(1 + i));
            tick();
        end
        req_valid = 1'b0;
        check_eq("mr_level_pre", level, 2);
        check_eq("mr_armed_pre", armed, 1);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("mr");
        tick();
        resetn = 1'b1;
        sec = 48'd300;
        nsec = 30'd0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq($sformatf("mr_tv_%0d", k), trig_valid, 0);
            check_eq($sformatf("mr_armed_%0d", k), armed, 0);
        end
        run_due("post_rst", 48'd300, 30'd0, 4'd5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rtclock_trigger_sched.md
# rtclock_trigger_sched

Time-triggered event scheduler driven by the rtclock `sec`/`nsec` time outputs. Requesters queue absolute trigger times (sec, nsec, id) into an in-order FIFO. The block arms the head entry, compares it against the running clock every cycle, and emits a one-cycle trigger pulse carrying the id when the clock reaches the target time. It sits beside `rtclock` in the tester core and sequences time-aligned actions such as generator start/stop and capture windows.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `SEC_WIDTH`, 48: width of seconds; matches rtclock `sec`.
- `NSEC_WIDTH`, 30: width of nanoseconds; matches rtclock `nsec`.
- `ID_WIDTH`, 4: request tag width.
- `clk`  in  1  clock shared with rtclock; single clock domain.
- `resetn`  in  1  reset, asynchronous, active-low.
- `sec`  in  SEC_WIDTH  current rtclock seconds.
- `nsec`  in  NSEC_WIDTH  current rtclock nanoseconds, 0..999_999_999.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when valid&ready.
- `req_sec`  in  SEC_WIDTH  target seconds.
- `req_nsec`  in  NSEC_WIDTH  target nanoseconds.
- `req_id`  in  ID_WIDTH  tag returned on trigger.
- `flush`  in  1  discard all queued and armed entries.
- `trig_valid`  out  1  one-cycle trigger pulse.
- `trig_id`  out  ID_WIDTH  tag of fired entry; valid with `trig_valid`.
- `trig_late`  out  1  entry was already past due when first compared.
- `req_err`  out  1  one-cycle pulse: accepted request had `req_nsec` ≥ 1_000_000_000; the entry is discarded.
- `armed`  out  1  an entry is held in the compare registers.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy 0..DEPTH; excludes the armed entry.

## Operation
- FIFO push when `req_valid & req_ready`. `req_ready = !full & !flush`. A pop in the same cycle does not raise `req_ready`.
- Requests with invalid nsec are consumed (handshake completes). They are not written to the FIFO, and `req_err` pulses in the next cycle.
- States:
  - IDLE: leave when FIFO not empty → LOAD.
  - LOAD: copy head into `t_sec`/`t_nsec`/`t_id`, pop FIFO, set `first` → ARMED.
  - ARMED: `hit = (sec > t_sec) | (sec == t_sec & nsec >= t_nsec)`. Unsigned full-width compare.
    - If `hit` → FIRE, with `late_r = first & (sec > t_sec | nsec > t_nsec)`. Exact equality is on time.
    - Clear `first` after the first ARMED cycle.
  - FIRE: `trig_valid`=1, `trig_id`=`t_id`, `trig_late`=`late_r`. Then → LOAD if FIFO not empty, else IDLE.
- Entries fire strictly in push order. An earlier-timed entry queued behind a later one fires late, immediately after its predecessor.
- `flush` (synchronous, sampled at edge):
  - Empties the FIFO and clears `armed`; next state is IDLE.
  - A hit detected in the same cycle is discarded.
  - A push in the flush cycle is impossible because `req_ready`=0.
- `armed` = state ∈ {LOAD, ARMED, FIRE}.

## Timing
- Reset values: `req_ready`=1, `trig_valid`=0, `trig_id`=0, `trig_late`=0, `req_err`=0, `armed`=0, `level`=0, state IDLE. Assertion of `resetn` mid-operation clears everything immediately, including the FIFO.
- Push in cycle N into an empty, idle block: LOAD in N+1, ARMED in N+2. If the target is already due, `trig_valid` is asserted in N+3, for a minimum latency of 3 cycles.
- An on-time entry sees `hit` in the first ARMED cycle M where clock ≥ target, and `trig_valid` is asserted in M+1. The trigger edge therefore lags the target by one clock period plus rtclock granularity.
- Consecutive due entries fire every 3 cycles (FIRE→LOAD→ARMED→FIRE).
- `level` and `req_ready` update on the edge following push/pop.

## Configuration
- `RTCLOCK_SCHED_LATE_DROP_EN` defined:
  - Entries that would fire with late=1 are dropped. FIRE does not assert `trig_valid`; `trig_late` pulses alone, acting as a drop indication.
  - Sequencing is otherwise identical.
- Macro not defined: late entries fire normally with `trig_valid`=1 and `trig_late`=1.

## Test plan
- Future target: clock at sec=5/nsec=0, push (5, 800, id=3).
  - Expect `trig_valid` with id=3 and late=0 exactly one cycle after the first `nsec` ≥ 800 at sec=5, and no earlier pulse.
- Past target: push (4, 0, id=1) while clock is at sec=5.
  - Expect a trigger 3 cycles after push with late=1.
  - With `RTCLOCK_SCHED_LATE_DROP_EN`: `trig_valid` stays 0 and `trig_late` pulses once.
- Full FIFO, DEPTH=4: push 5 far-future entries back-to-back.
  - Expect `level` to reach 4 with 1 armed.
  - `req_ready`=0 until the first fire plus LOAD.
  - Ids fire in push order.
- Invalid nsec: push nsec=1_000_000_000.
  - Expect `req_err` pulse, `level` unchanged, no trigger.
- Flush: with 3 queued entries and 1 armed entry whose hit occurs in the flush cycle, assert `flush`.
  - Expect no `trig_valid`, then `level`=0 and `armed`=0.
  - `req_ready`=1 afterwards.
- Reset mid-ARMED: deassert `resetn` with 2 entries queued.
  - Expect all outputs at reset values asynchronously.
  - No triggers after release until new pushes.
